// File: rtl/mult32_sequencer.sv
// mult32_sequencer: 32x32 -> 64-bit MULT/MULTU sequencer built around one
// shared unsigned 16x16 multiplier. Four partial products are accumulated
// over four cycles, then sign-corrected and written into the HI/LO
// registers owned by this block. Fixed 5-cycle latency from accepted start
// to the done pulse.
// Optional feature: define MULT_ACCUM_EN to enable MADD/MADDU-style
// accumulation into {hi,lo} when accum is latched high.

// Unsigned W x W -> 2W combinational multiplier shared by the sequencer.
module multiplier_16x16 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    // Plain unsigned product; operands zero-extended by the result width.
    always_comb begin
        p = a * b;
    end
endmodule

module mult32_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic              accum,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [DATA_W-1:0]   a_mag_q, a_mag_d;
    logic [DATA_W-1:0]   b_mag_q, b_mag_d;
    logic                neg_q, neg_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MULT_ACCUM_EN
    logic                accum_q, accum_d;
`else
    // accum has no effect in this build; kept only for port compatibility.
    logic                unused_accum;
    assign unused_accum = accum;
`endif

    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [DATA_W-1:0]   mul_p;
    logic [PROD_W-1:0]   pp_shifted;
    logic [PROD_W-1:0]   fin_r;
    logic [PROD_W-1:0]   fin_val;
    logic [DATA_W-1:0]   a_mag_in, b_mag_in;

    // Step-driven operand muxes: step[1] picks the A half, step[0] the B half,
    // giving AL*BL, AL*BH, AH*BL, AH*BH for steps 0..3.
    always_comb begin
        mul_a = step_q[1] ? a_mag_q[DATA_W-1:HALF_W] : a_mag_q[HALF_W-1:0];
        mul_b = step_q[0] ? b_mag_q[DATA_W-1:HALF_W] : b_mag_q[HALF_W-1:0];
    end

    multiplier_16x16 #(
        .W (HALF_W)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Align the current partial product to its weight in the 64-bit sum.
    always_comb begin
        case (step_q)
            2'd0:    pp_shifted = {{DATA_W{1'b0}}, mul_p};
            2'd3:    pp_shifted = {mul_p, {DATA_W{1'b0}}};
            default: pp_shifted = {{HALF_W{1'b0}}, mul_p, {HALF_W{1'b0}}};
        endcase
    end

    // Operand magnitudes; -0x80000000 wraps to 0x80000000, which is the
    // correct magnitude when read as unsigned.
    always_comb begin
        a_mag_in = (is_signed && a[DATA_W-1]) ? ('0 - a) : a;
        b_mag_in = (is_signed && b[DATA_W-1]) ? ('0 - b) : b;
    end

    // Sign correction of the magnitude product and optional accumulation.
    always_comb begin
        fin_r = neg_q ? ('0 - acc_q) : acc_q;
`ifdef MULT_ACCUM_EN
        fin_val = accum_q ? ({hi_q, lo_q} + fin_r) : fin_r;
`else
        fin_val = fin_r;
`endif
    end

    // Next-state logic for the IDLE -> MUL(x4) -> FIN sequence.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULT_ACCUM_EN
        accum_d = accum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_mag_d = a_mag_in;
                    b_mag_d = b_mag_in;
                    neg_d   = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
`ifdef MULT_ACCUM_EN
                    accum_d = accum;
`endif
                    acc_d   = '0;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                {hi_d, lo_d} = fin_val;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                step_d  = 2'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                step_d  = 2'd0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_ACCUM_EN
            accum_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULT_ACCUM_EN
            accum_q <= accum_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult32_sequencer.sv
// Self-checking bench for mult32_sequencer: directed vector table,
// hand-written multi-cycle sequences and randomized operations checked
// against a plain-arithmetic reference model.
module tb_mult32_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic        accum;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mult32_sequencer #(
        .DATA_W (32),
        .HALF_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .accum     (accum),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic        s;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present a request for one cycle, then scramble
    // the inputs so any late sampling would corrupt the result.
    task automatic launch(input logic s, input logic ac, input logic [31:0] va, input logic [31:0] vb);
        start     = 1'b1;
        is_signed = s;
        accum     = ac;
        a         = va;
        b         = vb;
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~s;
        accum     = ~ac;
        a         = $urandom;
        b         = $urandom;
    endtask

    // Count cycles until done (bounded); also count busy-high cycles seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 12) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] va, input logic [31:0] vb);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{va[31]}}, va});
        sb = $signed({{32{vb[31]}}, vb});
        if (s) return 64'(sa * sb);
        return {32'd0, va} * {32'd0, vb};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          bc;
        int          seen;
        logic [63:0] model;
        logic [63:0] p;
        logic        rs;
        logic        rac;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{1'b0, 32'd2,          32'd6,          32'h00000000, 32'h0000000C};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{1'b0, 32'd1504,       32'd4120,       32'h00000000, 32'h005E8D00};
        vecs[3] = '{1'b1, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[4] = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,   32'h80000000,   32'h00000000, 32'h80000000};
        vecs[6] = '{1'b1, 32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000};
        vecs[7] = '{1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; accum = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].s, 1'b0, vecs[i].va, vecs[i].vb);
            wait_done(lat, bc);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd5);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].ehi, vecs[i].elo});
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
            check($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].ehi, vecs[i].elo});
        end

        // start while busy is ignored; start in the done cycle is accepted
        launch(1'b0, 1'b0, 32'd16, 32'd23);
        @(negedge clk);
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("busy_start_latency", 64'(lat), 64'd3);
        check("busy_start_hilo", {hi, lo}, 64'd368);
        launch(1'b0, 1'b0, 32'd124, 32'd215);
        wait_done(lat, bc);
        check("b2b_latency", 64'(lat), 64'd5);
        check("b2b_hilo", {hi, lo}, 64'd26660);
        @(negedge clk);

        // Reset mid-operation aborts without writing hi/lo
        launch(1'b0, 1'b0, 32'd25, 32'd62);
        wait_done(lat, bc);
        check("pre_abort_hilo", {hi, lo}, 64'd1550);
        @(negedge clk);
        launch(1'b0, 1'b0, 32'd156, 32'd233);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Accumulate request
        launch(1'b0, 1'b0, 32'd2, 32'd6);
        wait_done(lat, bc);
        check("acc_first_hilo", {hi, lo}, 64'd12);
        @(negedge clk);
        launch(1'b0, 1'b1, 32'd3, 32'd5);
        wait_done(lat, bc);
        check("acc_latency", 64'(lat), 64'd5);
`ifdef MULT_ACCUM_EN
        check("acc_second_hilo", {hi, lo}, 64'd27);
`else
        check("acc_second_hilo", {hi, lo}, 64'd15);
`endif
        @(negedge clk);

        // Randomized operations against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model = '0;
        for (int i = 0; i < 40; i++) begin
            rs  = 1'($urandom_range(1, 0));
            rac = 1'($urandom_range(1, 0));
            case ($urandom_range(3, 0))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(3, 0))
                0:       rb = 32'h80000000;
                1:       rb = 32'd0;
                default: rb = $urandom;
            endcase
            p = ref_prod(rs, ra, rb);
`ifdef MULT_ACCUM_EN
            model = rac ? (model + p) : p;
`else
            model = p;
`endif
            launch(rs, rac, ra, rb);
            wait_done(lat, bc);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd5);
            check($sformatf("rand%0d_hilo s=%0d a=%h b=%h", i, rs, ra, rb), {hi, lo}, model);
            if (i % 2 == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
